// File: rtl/multi_event_router.sv
// multi_event_router
//   Collects events from NUMCHANNELS channel FIFOs and emits them one at a time
//   as parity-protected packets. In lightpix mode a batch is forwarded only when
//   enough channels are non-empty at the same time inside an integration window.
//   A batch that misses the window is popped and discarded, and each discarded
//   event is counted.
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   input_event         per-channel FIFO head data (WIDTH-1 bits each)
//   local_fifo_empty    per-channel empty flags
//   read_local_fifo_n   per-channel pop strobes, active low, one cycle each
//   lightpix_mode       enables coincidence integration
//   hit_threshold       minimum number of simultaneous hits (0 counts as 1)
//   timeout             integration window length in clk cycles
//   event_out           {odd parity, payload}
//   event_valid/ready   output handshake
//   dropped_count       saturating count of events discarded by timeout
//   busy                FSM is not in IDLE
module multi_event_router #(
    parameter int WIDTH       = 64,
    parameter int NUMCHANNELS = 64,
    parameter int TIMER_W     = 8,
    parameter int CW          = $clog2(NUMCHANNELS + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUMCHANNELS-1:0][WIDTH-2:0]     input_event,
    input  logic [NUMCHANNELS-1:0]                local_fifo_empty,
    output logic [NUMCHANNELS-1:0]                read_local_fifo_n,
    input  logic                                  lightpix_mode,
    input  logic [CW-1:0]                         hit_threshold,
    input  logic [TIMER_W-1:0]                    timeout,
    output logic [WIDTH-1:0]                      event_out,
    output logic                                  event_valid,
    input  logic                                  event_ready,
    output logic [15:0]                           dropped_count,
    output logic                                  busy
);

    localparam int IW = (NUMCHANNELS > 1) ? $clog2(NUMCHANNELS) : 1;

    typedef enum logic [2:0] {IDLE, INTEGRATE, GRANT, LATCH, OFFER, DUMP} state_t;

    state_t                 state, state_nx;
    logic [TIMER_W-1:0]     timer;
    logic [NUMCHANNELS-1:0] pending;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          grant_idx;
    logic [WIDTH-2:0]       payload;

    logic [CW-1:0]          hits;
    logic [CW-1:0]          thr_eff;
    logic                   sel_found;
    logic [IW-1:0]          sel_idx;
    logic [IW-1:0]          sel_next;
    logic [16:0]            drop_sum;

    function automatic logic [CW-1:0] popcnt(input logic [NUMCHANNELS-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUMCHANNELS; i++) cnt = cnt + CW'(v[i]);
        return cnt;
    endfunction

    assign hits     = popcnt(~local_fifo_empty);
    // A zero threshold would accept an empty batch; treat it as 1.
    assign thr_eff  = (hit_threshold == '0) ? CW'(1) : hit_threshold;
    assign drop_sum = {1'b0, dropped_count} + 17'(popcnt(pending));

    // Round-robin pick: first pending channel at or after rr_ptr, wrapping.
    always_comb begin : p_sel
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = 0; off < NUMCHANNELS; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUMCHANNELS) idx = idx - NUMCHANNELS;
            if (!sel_found && pending[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(idx);
            end
        end
    end

    assign sel_next = (sel_idx == IW'(NUMCHANNELS - 1)) ? '0 : sel_idx + 1'b1;

    // Next state and pop strobes, all decoded from the current state.
    always_comb begin
        state_nx          = state;
        read_local_fifo_n = '1;
        case (state)
            IDLE:      if (!(&local_fifo_empty)) state_nx = INTEGRATE;
            INTEGRATE: begin
                if (!lightpix_mode)          state_nx = GRANT;
                else if (hits >= thr_eff)    state_nx = GRANT;   // acceptance beats timeout
                else if (timer >= timeout)   state_nx = DUMP;
            end
            GRANT: begin
                // Snapshot can be empty if a FIFO drained before integration
                // sampled it; nothing to serve then.
                if (sel_found) begin
                    read_local_fifo_n[sel_idx] = 1'b0;
                    state_nx = LATCH;
                end else begin
                    state_nx = IDLE;
                end
            end
            LATCH:     state_nx = OFFER;
            OFFER:     if (event_ready) state_nx = (|pending) ? GRANT : IDLE;
            DUMP: begin
                read_local_fifo_n = ~pending;
                state_nx = IDLE;
            end
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer         <= '0;
            pending       <= '0;
            rr_ptr        <= '0;
            grant_idx     <= '0;
            payload       <= '0;
            dropped_count <= '0;
        end else begin
            case (state)
                IDLE:      timer <= '0;
                INTEGRATE: begin
                    if (timer != '1) timer <= timer + 1'b1;
                    pending <= ~local_fifo_empty;
                end
                GRANT: begin
                    if (sel_found) begin
                        pending[sel_idx] <= 1'b0;
                        rr_ptr           <= sel_next;
                        grant_idx        <= sel_idx;
                    end
                end
                LATCH:     payload <= input_event[grant_idx];
                DUMP: begin
                    dropped_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                    pending       <= '0;
                end
                default: ;
            endcase
        end
    end

    assign event_out   = {~^payload, payload};
    assign event_valid = (state == OFFER);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_multi_event_router.sv
// Scoreboard bench for multi_event_router: a one-entry-per-channel FIFO model,
// queues of expected pop order and expected packets, checked as pops and
// handshakes are observed.
module tb_multi_event_router;
    localparam int W  = 16;
    localparam int N  = 16;
    localparam int TW = 8;
    localparam int CW = $clog2(N + 1);

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [N-1:0][W-2:0]    input_event;
    logic [N-1:0]           local_fifo_empty;
    logic [N-1:0]           read_local_fifo_n;
    logic                   lightpix_mode;
    logic [CW-1:0]          hit_threshold;
    logic [TW-1:0]          timeout;
    logic [W-1:0]           event_out;
    logic                   event_valid;
    logic                   event_ready;
    logic [15:0]            dropped_count;
    logic                   busy;

    always #5 clk = ~clk;

    multi_event_router #(.WIDTH(W), .NUMCHANNELS(N), .TIMER_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .input_event(input_event),
        .local_fifo_empty(local_fifo_empty), .read_local_fifo_n(read_local_fifo_n),
        .lightpix_mode(lightpix_mode), .hit_threshold(hit_threshold), .timeout(timeout),
        .event_out(event_out), .event_valid(event_valid), .event_ready(event_ready),
        .dropped_count(dropped_count), .busy(busy)
    );

    int total = 0, bad = 0, cyc = 0, pop_total = 0, vld_total = 0;
    int pop_cyc[N];
    int pop_q[$];
    logic [W-1:0] ev_q[$];
    logic s_valid, s_busy;
    logic [W-1:0] s_out;
    logic [15:0] s_drop;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Odd parity bit: 1 when the payload holds an even number of ones.
    function automatic logic par(input logic [W-2:0] d);
        int n = 0;
        for (int i = 0; i < W - 1; i++) if (d[i]) n++;
        return (n % 2 == 0);
    endfunction

    task automatic load(input int c, input logic [W-2:0] d);
        input_event[c]      = d;
        local_fifo_empty[c] = 1'b0;
    endtask

    task automatic expect_ev(input int c, input logic [W-2:0] d);
        pop_q.push_back(c);
        ev_q.push_back({par(d), d});
    endtask

    // One clock: sample at the falling edge, apply pops after the rising edge.
    task automatic tick();
        logic [N-1:0] m;
        @(negedge clk);
        cyc++;
        s_valid = event_valid;
        s_busy  = busy;
        s_out   = event_out;
        s_drop  = dropped_count;
        m       = ~read_local_fifo_n;
        if (s_valid) vld_total++;
        for (int c = 0; c < N; c++) begin
            if (m[c]) begin
                pop_total++;
                pop_cyc[c] = cyc;
                chk("pop_nonempty", local_fifo_empty[c], 1'b0);
                chk("pop_expected", pop_q.size() != 0, 1'b1);
                if (pop_q.size() != 0) chk("pop_order", c, pop_q.pop_front());
            end
        end
        if (s_valid && event_ready) begin
            chk("ev_expected", ev_q.size() != 0, 1'b1);
            if (ev_q.size() != 0) chk("event_out", s_out, ev_q.pop_front());
        end
        @(posedge clk);
        #1;
        local_fifo_empty = local_fifo_empty | m;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_valid && n < 100);
        chk("wait_valid", s_valid, 1'b1);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            tick();
            n++;
        end while ((pop_q.size() != 0 || ev_q.size() != 0 || s_busy) && n < 300);
        chk("wait_done", (pop_q.size() == 0 && ev_q.size() == 0 && !s_busy), 1'b1);
    endtask

    initial begin
        int n, t0, v0, p0;
        logic [W-1:0] o0;
        input_event      = '0;
        local_fifo_empty = '1;
        lightpix_mode    = 1'b0;
        hit_threshold    = '0;
        timeout          = '0;
        event_ready      = 1'b1;

        // Reset state
        #12;
        chk("rst_valid", event_valid, 1'b0);
        chk("rst_rd_n", read_local_fifo_n, {N{1'b1}});
        chk("rst_busy", busy, 1'b0);
        chk("rst_out", event_out, 16'h8000);
        chk("rst_drop", dropped_count, 16'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Plain forwarding: ch3 and ch10, latency and spacing
        load(3, 15'h5);
        load(10, 15'hA);
        expect_ev(3, 15'h5);
        expect_ev(10, 15'hA);
        t0 = cyc;
        wait_valid(n);
        chk("latency", n, 5);
        wait_done();
        chk("pop_ch3_cyc", pop_cyc[3] - t0, 3);
        chk("pop_gap", pop_cyc[10] - pop_cyc[3], 3);

        // Lightpix timeout: single hit below threshold is dumped
        lightpix_mode = 1'b1;
        hit_threshold = 5'd3;
        timeout       = 8'd5;
        v0 = vld_total;
        load(7, 15'h77);
        pop_q.push_back(7);
        wait_done();
        chk("lp_no_valid", vld_total - v0, 0);
        chk("dropped1", s_drop, 16'd1);

        // Lightpix acceptance: second hit arrives inside the window
        hit_threshold = 5'd2;
        timeout       = 8'd10;
        expect_ev(1, 15'h11);
        expect_ev(2, 15'h22);
        load(1, 15'h11);
        tick();
        tick();
        load(2, 15'h22);
        wait_done();
        chk("dropped_keep", s_drop, 16'd1);

        // Round robin: grant ch4 moves the pointer to 5
        lightpix_mode = 1'b0;
        load(4, 15'h44);
        expect_ev(4, 15'h44);
        wait_done();
        load(2, 15'h202);
        load(5, 15'h505);
        load(9, 15'h7909);
        expect_ev(5, 15'h505);
        expect_ev(9, 15'h7909);
        expect_ev(2, 15'h202);
        wait_done();

        // Backpressure: hold OFFER for 20 cycles
        event_ready = 1'b0;
        load(0, 15'h100);
        load(6, 15'h066);
        expect_ev(6, 15'h066);
        expect_ev(0, 15'h100);
        wait_valid(n);
        p0 = pop_total;
        o0 = s_out;
        repeat (20) begin
            tick();
            chk("hold_valid", s_valid, 1'b1);
            chk("hold_out", s_out, o0);
        end
        chk("hold_no_pop", pop_total - p0, 0);
        event_ready = 1'b1;
        wait_done();

        // Reset during OFFER
        event_ready = 1'b0;
        load(11, 15'h3C);
        pop_q.push_back(11);
        wait_valid(n);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", event_valid, 1'b0);
        chk("arst_rd_n", read_local_fifo_n, {N{1'b1}});
        chk("arst_busy", busy, 1'b0);
        chk("arst_drop", dropped_count, 16'h0);
        chk("arst_out", event_out, 16'h8000);
        tick();
        tick();
        reset_n     = 1'b1;
        event_ready = 1'b1;
        load(8, 15'h0F0);
        expect_ev(8, 15'h0F0);
        wait_done();
        chk("resume_drop", s_drop, 16'h0);

        chk("sb_drain", pop_q.size() + ev_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
